clock_display_scan: RTL and testbench
=====================================

Name: clock_display_scan

Overview:
- Downstream consumer of the BCD time-of-day counter.
- Takes packed-BCD hh/mm/ss bytes and drives an 8-digit, common-anode, multiplexed seven-segment display. Digit layout is H1 H0 - M1 M0 - S1 S0.
- Time-multiplexes one digit at a time at a programmable refresh rate.
- Snapshots the time once per display frame, so a rollover during a scan never shows mixed old/new digits.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays lit. Legal range is 1 or more; 1 advances the digit every cycle. The prescaler is $clog2(REFRESH_DIV) bits wide, minimum 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- hh  input  8  hours, packed BCD: [7:4] tens, [3:0] units.
- mm  input  8  minutes, packed BCD.
- ss  input  8  seconds, packed BCD.
- an  output  8  digit enables, active-low; an[i] lights digit position i.
- seg  output  7  segment cathodes, active-low; seg[0]=a through seg[6]=g.
- dp  output  1  decimal point, active-low; tied off (always 1).

Behaviour:
- Reset (synchronous, when reset=1 at a clk edge):
  - prescaler=0, idx=0, snapshot regs=0.
  - an=8'hFF, seg=7'h7F, dp=1.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps.
  - At terminal count, idx (3 bits) increments modulo 8; idx 7 wraps to 0.
- Snapshot:
  - Loads hh/mm/ss on the edge where prescaler is at terminal count and idx=7, i.e. the same edge idx goes to 0.
  - Holds for the entire frame. Input changes at any other time are invisible until the next frame.
- Outputs are registered from the current idx and the current snapshot, so they lag idx by one cycle.
  - an = ~(8'b1 << idx).
  - seg = pattern for the digit selected by idx.
- Digit mapping (idx: source):
  - 0: ss[3:0]
  - 1: ss[7:4]
  - 2: dash
  - 3: mm[3:0]
  - 4: mm[7:4]
  - 5: dash
  - 6: hh[3:0]
  - 7: hh[7:4]
- Segment patterns (active-low, {g..a}):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
  - dash=7'h3F, blank=7'h7F
- Invalid BCD nibble (A–F) on any digit: blank (7'h7F). No range checking across digits; 8'h99 shows "99".
- First frame after reset shows 00-00-00, because the snapshot is zero until the first idx wrap.
- Reset mid-frame:
  - Abandons the scan; no partial state persists.
  - Cycle after reset deasserts: an=8'hFE, and seg shows the snapshot digit 0, which is 0 after reset.
- Exactly one an bit is low in every non-reset cycle, so there is no ghosting overlap.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when the snapshot hh[7:4]==0, digit position 7 shows blank (7'h7F) while an[7] still asserts in its slot. All other digits are unaffected.
- Undefined: hh[7:4]==0 shows 7'h40.

Decomposition:
- Package clock_display_pkg holds:
  - SEG_* pattern constants (digits 0–9, SEG_DASH, SEG_BLANK).
  - Digit-position constants IDX_S0..IDX_H1.
  - Type seg_t for the 7-bit pattern.
- Sub-module seven_seg_decode:
  - Purely combinational: 4-bit nibble in, seg_t out, blank for A–F.
  - Instantiated once, fed by the idx-selected nibble.
- Top level holds the prescaler, idx counter, snapshot regs, dash/blank override and output registers.

Test Plan (REFRESH_DIV=4):
1. Hold reset 3 cycles → an=8'hFF, seg=7'h7F, dp=1 throughout. Release → next cycle an=8'hFE, seg=7'h40; an advances to 8'hFD after 4 cycles.
2. hh=8'h12, mm=8'h34, ss=8'h56 before the first wrap → second frame, each digit held 4 cycles, gives seg sequence 02,12,3F,19,30,3F,24,79 with an FE,FD,FB,F7,EF,DF,BF,7F.
3. Tearing check: during frame 2 at idx=3, change ss to 8'h57 → remainder of frame unchanged. Next frame idx0 shows 7'h78.
4. ss=8'h5C → idx0 seg=7'h7F and idx1 seg=7'h12. mm=8'hF0 → idx4 blank.
5. Assert reset for 1 cycle while idx=5 → cycle after release an=8'hFE. Full idx 0..7 sequence restarts with correct 4-cycle slot timing.
6. hh=8'h09 → idx7 seg=7'h7F with LEADING_ZERO_BLANK_EN, 7'h40 without. hh=8'h10 → 7'h79 in both builds.

Source files
------------

// File: rtl/clock_display_pkg.sv
// rtl/clock_display_pkg.sv - segment patterns, digit positions and seg_t shared by the display scanner.
package clock_display_pkg;

  typedef logic [6:0] seg_t;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_DASH  = 7'h3F;
  localparam seg_t SEG_BLANK = 7'h7F;

  localparam logic [2:0] IDX_S0      = 3'd0;
  localparam logic [2:0] IDX_S1      = 3'd1;
  localparam logic [2:0] IDX_DASH_LO = 3'd2;
  localparam logic [2:0] IDX_M0      = 3'd3;
  localparam logic [2:0] IDX_M1      = 3'd4;
  localparam logic [2:0] IDX_DASH_HI = 3'd5;
  localparam logic [2:0] IDX_H0      = 3'd6;
  localparam logic [2:0] IDX_H1      = 3'd7;

endpackage

// File: rtl/clock_display_scan_decode.sv
// rtl/clock_display_scan_decode.sv - combinational BCD nibble to active-low seven-segment pattern.
module seven_seg_decode
  import clock_display_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - multiplexed 8-digit hh-mm-ss seven-segment scanner with per-frame snapshot.
// Define LEADING_ZERO_BLANK_EN to blank the hours tens digit when it is zero.
module clock_display_scan
  import clock_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);

  logic [PRE_W-1:0] prescaler_q, prescaler_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       snap_hh_q, snap_hh_d;
  logic [7:0]       snap_mm_q, snap_mm_d;
  logic [7:0]       snap_ss_q, snap_ss_d;
  logic [7:0]       an_q, an_d;
  seg_t             seg_q, seg_d;
  logic             tc;
  logic [3:0]       nibble;
  seg_t             dec_seg;

  seven_seg_decode u_decode (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    tc          = (prescaler_q == PRE_MAX);
    prescaler_d = tc ? '0 : prescaler_q + PRE_W'(1);
    idx_d       = tc ? idx_q + 3'd1 : idx_q;

    // Snapshot only on the edge that wraps idx back to 0, so a frame never mixes times
    snap_hh_d = snap_hh_q;
    snap_mm_d = snap_mm_q;
    snap_ss_d = snap_ss_q;
    if (tc && idx_q == IDX_H1) begin
      snap_hh_d = hh;
      snap_mm_d = mm;
      snap_ss_d = ss;
    end

    nibble = 4'h0;
    case (idx_q)
      IDX_S0:  nibble = snap_ss_q[3:0];
      IDX_S1:  nibble = snap_ss_q[7:4];
      IDX_M0:  nibble = snap_mm_q[3:0];
      IDX_M1:  nibble = snap_mm_q[7:4];
      IDX_H0:  nibble = snap_hh_q[3:0];
      IDX_H1:  nibble = snap_hh_q[7:4];
      default: nibble = 4'h0;
    endcase

    an_d  = ~(8'b1 << idx_q);
    seg_d = dec_seg;
    if (idx_q == IDX_DASH_LO || idx_q == IDX_DASH_HI) begin
      seg_d = SEG_DASH;
    end
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_q == IDX_H1 && snap_hh_q[7:4] == 4'h0) begin
      seg_d = SEG_BLANK;
    end
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_q <= '0;
      idx_q       <= 3'd0;
      snap_hh_q   <= 8'h00;
      snap_mm_q   <= 8'h00;
      snap_ss_q   <= 8'h00;
      an_q        <= 8'hFF;
      seg_q       <= SEG_BLANK;
    end else begin
      prescaler_q <= prescaler_d;
      idx_q       <= idx_d;
      snap_hh_q   <= snap_hh_d;
      snap_mm_q   <= snap_mm_d;
      snap_ss_q   <= snap_ss_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_clock_display_scan.sv
// tb/tb_clock_display_scan.sv - scoreboard bench for clock_display_scan with REFRESH_DIV=4.
module tb_clock_display_scan;

  localparam int DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] H1_ZERO = 7'h7F;
`else
  localparam logic [6:0] H1_ZERO = 7'h40;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] hh = 8'h00, mm = 8'h00, ss = 8'h00;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  clock_display_scan #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .hh    (hh),
    .mm    (mm),
    .ss    (ss),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  task automatic push_one(input logic [7:0] a, input logic [6:0] s);
    exp_q.push_back({a, s, 1'b1});
  endtask

  task automatic push_frame(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                            input logic [6:0] p3, input logic [6:0] p4, input logic [6:0] p5,
                            input logic [6:0] p6, input logic [6:0] p7);
    logic [6:0] p [8];
    logic [7:0] a [8];
    p = '{p0, p1, p2, p3, p4, p5, p6, p7};
    a = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    for (int d = 0; d < 8; d++)
      for (int k = 0; k < DIV; k++)
        push_one(a[d], p[d]);
  endtask

  task automatic drain(input int n, input string tag);
    logic [15:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL %s: scoreboard empty, observed an=%h seg=%h dp=%b", tag, an, seg, dp);
      end else begin
        e = exp_q.pop_front();
        assert ({an, seg, dp} === e) else begin
          errors++;
          $error("FAIL %s[%0d]: observed an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                 tag, i, an, seg, dp, e[15:8], e[7:1], e[0]);
        end
      end
    end
  endtask

  initial begin
    // Reset held 3 cycles
    for (int i = 0; i < 3; i++) push_one(8'hFF, 7'h7F);
    drain(3, "reset_hold");
    reset = 1'b0;
    hh = 8'h12; mm = 8'h34; ss = 8'h56;

    push_frame(7'h40, 7'h40, 7'h3F, 7'h40, 7'h40, 7'h3F, 7'h40, 7'h40);
    drain(32, "frame0_zero");

    push_frame(7'h02, 7'h12, 7'h3F, 7'h19, 7'h30, 7'h3F, 7'h24, 7'h79);
    drain(12, "frame1_pre");
    ss = 8'h57;
    drain(20, "frame1_tear");

    push_frame(7'h78, 7'h12, 7'h3F, 7'h19, 7'h30, 7'h3F, 7'h24, 7'h79);
    drain(8, "frame2_pre");
    ss = 8'h5C; mm = 8'hF0;
    drain(24, "frame2_post");

    push_frame(7'h7F, 7'h12, 7'h3F, 7'h40, 7'h7F, 7'h3F, 7'h24, 7'h79);
    drain(32, "frame3_invalid");

    // Reset mid-frame, during slot 5
    push_frame(7'h7F, 7'h12, 7'h3F, 7'h40, 7'h7F, 7'h3F, 7'h24, 7'h79);
    drain(21, "frame4_partial");
    exp_q.delete();
    reset = 1'b1;
    hh = 8'h09; mm = 8'h59; ss = 8'h30;
    push_one(8'hFF, 7'h7F);
    drain(1, "reset_mid");
    reset = 1'b0;

    push_frame(7'h40, 7'h40, 7'h3F, 7'h40, 7'h40, 7'h3F, 7'h40, 7'h40);
    drain(32, "restart_frame0");

    push_frame(7'h40, 7'h30, 7'h3F, 7'h10, 7'h12, 7'h3F, 7'h10, H1_ZERO);
    drain(4, "lzb_pre");
    hh = 8'h10;
    drain(28, "lzb_frame");

    push_frame(7'h40, 7'h30, 7'h3F, 7'h10, 7'h12, 7'h3F, 7'h40, 7'h79);
    drain(32, "hours_ten");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
